// File: rtl/conv_window_gen.sv
// conv_window_gen -- streaming 3x3xCH sliding-window generator.
//
// Takes a raster-order pixel stream (CH signed channels per pixel), keeps the
// two previous image lines in line buffers and presents one complete 3x3xCH
// window for every valid (non-padded) output position. Windows are handed to
// the multiply/reduce stage as a flat NWIN-entry operand array.
//
// Ports:
//   clk      clock
//   rst      asynchronous active-high reset (counters, window, valid/last)
//   clr      synchronous frame restart; wins over a simultaneous accept
//   s_valid  input pixel valid
//   s_ready  input pixel accepted when s_valid && s_ready (= !m_valid || m_ready)
//   s_data   one pixel, CH signed samples
//   m_valid  window valid
//   m_ready  downstream accepts window
//   m_win    window, index (ky*3+kx)*CH + c; ky=0 oldest row, kx=0 oldest column
//   m_last   marks the final window of a frame
module conv_window_gen #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int CH     = 3,
  parameter int IWIDTH = 8,
  localparam int NWIN  = 9 * CH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [IWIDTH-1:0] s_data [CH],
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [IWIDTH-1:0] m_win [NWIN],
  output logic                     m_last
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          m_valid_q, m_valid_d;
  logic          m_last_q, m_last_d;

  logic signed [IWIDTH-1:0] win_q [3][3][CH];
  logic signed [IWIDTH-1:0] win_d [3][3][CH];

  // lb1 holds row r-1, lb0 holds row r-2 at each column.
  logic signed [IWIDTH-1:0] lb0_q [IMG_W][CH];
  logic signed [IWIDTH-1:0] lb1_q [IMG_W][CH];

  logic accept;
  logic col_end;
  logic row_end;
  logic emit;

  assign s_ready = !m_valid_q || m_ready;
  // A clr cycle drops the offered pixel even though s_ready may be high.
  assign accept  = s_valid && s_ready && !clr;
  assign col_end = (col_q == COL_LAST);
  assign row_end = (row_q == ROW_LAST);
  assign emit    = accept && (row_q >= ROW_TWO) && (col_q >= COL_TWO);

  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    win_d     = win_q;

    if (clr) begin
      col_d     = '0;
      row_d     = '0;
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end else begin
      if (m_ready) begin
        m_valid_d = 1'b0;
        m_last_d  = 1'b0;
      end

      // accept implies the current window is either consumed or invalid,
      // so the shift never disturbs a held output.
      if (accept) begin
        for (int ky = 0; ky < 3; ky++) begin
          for (int c = 0; c < CH; c++) begin
            win_d[ky][0][c] = win_q[ky][1][c];
            win_d[ky][1][c] = win_q[ky][2][c];
          end
        end
        for (int c = 0; c < CH; c++) begin
          win_d[0][2][c] = lb0_q[col_q][c];
          win_d[1][2][c] = lb1_q[col_q][c];
          win_d[2][2][c] = s_data[c];
        end

        if (col_end) begin
          col_d = '0;
          row_d = row_end ? '0 : row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end

        if (emit) begin
          m_valid_d = 1'b1;
          m_last_d  = row_end && col_end;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q     <= '0;
      row_q     <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      for (int ky = 0; ky < 3; ky++) begin
        for (int kx = 0; kx < 3; kx++) begin
          for (int c = 0; c < CH; c++) begin
            win_q[ky][kx][c] <= '0;
          end
        end
      end
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      win_q     <= win_d;
    end
  end

  // Line buffers carry no reset: rows 0-1 of every frame rewrite them
  // before any window can use their contents.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int c = 0; c < CH; c++) begin
        lb0_q[col_q][c] <= lb1_q[col_q][c];
        lb1_q[col_q][c] <= s_data[c];
      end
    end
  end

  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;

  for (genvar ky = 0; ky < 3; ky++) begin : g_row
    for (genvar kx = 0; kx < 3; kx++) begin : g_col
      for (genvar c = 0; c < CH; c++) begin : g_ch
        assign m_win[(ky*3+kx)*CH+c] = win_q[ky][kx][c];
      end
    end
  end

endmodule
